// File: rtl/mdu_core.sv
// Multiply/divide unit with HI/LO registers.
// Runs one multi-cycle operation at a time and commits HI/LO when it completes.
module mdu_core #(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  mdu_op,
    input  logic [1:0]  mthilo,
    input  logic [1:0]  mfhilo,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    input  logic        flush,
    output logic        start,
    output logic        busy,
    output logic [31:0] rdata,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state | meaning
    // IDLE  | no operation in flight; accepts mdu_op or mthilo
    // RUN   | operation in flight; count holds remaining busy cycles
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [3:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;

    logic        op_valid;
    logic        op_is_div;
    logic        sgn;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] product;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;
    logic [63:0] result;

    always_comb begin
        op_valid  = (mdu_op >= 4'd1) && (mdu_op <= 4'd8);
        op_is_div = (mdu_op == 4'd3) || (mdu_op == 4'd4);
        start     = reset_n && (state == IDLE) && !flush && op_valid;
    end

    // Even opcodes are the signed variants.
    always_comb begin
        sgn     = ~op_q[0];
        a_ext   = {{32{sgn & a_q[31]}}, a_q};
        b_ext   = {{32{sgn & b_q[31]}}, b_q};
        product = a_ext * b_ext;
    end

    // Signed divide via magnitudes; -2^31 / -1 falls out as 0x80000000 rem 0.
    always_comb begin
        a_neg = sgn & a_q[31];
        b_neg = sgn & b_q[31];
        a_mag = a_neg ? (32'd0 - a_q) : a_q;
        b_mag = b_neg ? (32'd0 - b_q) : b_q;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quot  = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem   = a_neg ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        result = {hi, lo};
        case (op_q)
            4'd1, 4'd2: result = product;
            4'd3, 4'd4: begin
                if (b_q != 32'd0) result = {rem, quot};
            end
            4'd5, 4'd6: result = {hi, lo} + product;
            4'd7, 4'd8: result = {hi, lo} - product;
            default:    result = {hi, lo};
        endcase
    end

    always_comb begin
        case (mfhilo)
            2'b01:   rdata = lo;
            2'b10:   rdata = hi;
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            op_q  <= 4'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            busy  <= 1'b0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q  <= mdu_op;
                        a_q   <= rs_val;
                        b_q   <= rt_val;
                        count <= op_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
                        busy  <= 1'b1;
                        state <= RUN;
                    end else if (!flush) begin
                        if (mthilo == 2'b01) lo <= rs_val;
                        else if (mthilo == 2'b11) hi <= rs_val;
                    end
                end
                RUN: begin
                    if (count == CNT_W'(1)) begin
                        {hi, lo} <= result;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        count <= count - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_core.sv
// Bench for mdu_core: directed literal checks plus randomized traffic
// compared every cycle against an arithmetic model of HI/LO and busy time.
module tb_mdu_core;

    localparam int MULN = 5;
    localparam int DIVN = 10;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [3:0]  mdu_op = 4'd0;
    logic [1:0]  mthilo = 2'b00;
    logic [1:0]  mfhilo = 2'b00;
    logic [31:0] rs_val = 32'd0;
    logic [31:0] rt_val = 32'd0;
    logic        flush = 1'b0;
    logic        start;
    logic        busy;
    logic [31:0] rdata;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic [3:0]  m_op;
    int          m_left;

    mdu_core #(.MUL_CYCLES(MULN), .DIV_CYCLES(DIVN)) dut (
        .clk(clk), .reset_n(reset_n), .mdu_op(mdu_op), .mthilo(mthilo),
        .mfhilo(mfhilo), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
        .start(start), .busy(busy), .rdata(rdata), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] acc);
        longint sa, sb, ua, ub;
        logic [63:0] prod;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        prod = (op inside {4'd2, 4'd6, 4'd8}) ? 64'(sa * sb) : 64'(ua * ub);
        case (op)
            4'd1, 4'd2: return prod;
            4'd3: return (b == 32'd0) ? acc : {32'(ua % ub), 32'(ua / ub)};
            4'd4: return (b == 32'd0) ? acc : {32'(sa % sb), 32'(sa / sb)};
            4'd5, 4'd6: return acc + prod;
            4'd7, 4'd8: return acc - prod;
            default: return acc;
        endcase
    endfunction

    // Reference model: remaining busy cycles plus arithmetic result at completion.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hi <= 32'd0; m_lo <= 32'd0; m_a <= 32'd0; m_b <= 32'd0;
            m_op <= 4'd0;  m_left <= 0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) {m_hi, m_lo} <= ref_result(m_op, m_a, m_b, {m_hi, m_lo});
        end else if (!flush && mdu_op >= 4'd1 && mdu_op <= 4'd8) begin
            m_op <= mdu_op; m_a <= rs_val; m_b <= rt_val;
            m_left <= (mdu_op == 4'd3 || mdu_op == 4'd4) ? DIVN : MULN;
        end else if (!flush && mthilo == 2'b01) begin
            m_lo <= rs_val;
        end else if (!flush && mthilo == 2'b11) begin
            m_hi <= rs_val;
        end
    end

    always @(negedge clk) begin : cmp
        logic        es;
        logic [31:0] erd;
        #2;
        if (chk_en) begin
            es  = reset_n && (m_left == 0) && !flush && (mdu_op >= 4'd1) && (mdu_op <= 4'd8);
            erd = (mfhilo == 2'b01) ? m_lo : (mfhilo == 2'b10) ? m_hi : 32'd0;
            chk("cmp_start", 32'(start), 32'(es));
            chk("cmp_busy", 32'(busy), 32'(m_left > 0));
            chk("cmp_hi", hi, m_hi);
            chk("cmp_lo", lo, m_lo);
            chk("cmp_rdata", rdata, erd);
        end
    end

    task automatic cyc(input logic [3:0] op, input logic [1:0] mth, input logic [31:0] a,
                       input logic [31:0] b, input logic fl);
        @(negedge clk);
        mdu_op = op; mthilo = mth; rs_val = a; rt_val = b; flush = fl;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(4'd0, 2'b00, 32'd0, 32'd0, 1'b0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1 reset_n = 1'b0;
        chk_en = 1'b1;
        cyc(4'd1, 2'b00, 32'd5, 32'd6, 1'b0);
        #1;
        chk("start_in_reset", 32'(start), 32'd0);
        chk("busy_reset", 32'(busy), 32'd0);
        chk("hi_reset", hi, 32'd0);
        chk("lo_reset", lo, 32'd0);
        cyc(4'd0, 2'b00, 32'd0, 32'd0, 1'b0);
        reset_n = 1'b1;

        // Move-to HI and read back through rdata.
        cyc(4'd0, 2'b11, 32'h1234_5678, 32'd0, 1'b0);
        idle(1);
        mfhilo = 2'b10;
        #1 chk("rdata_hi", rdata, 32'h1234_5678);
        mfhilo = 2'b00;
        #1 chk("rdata_none", rdata, 32'd0);

        // MULT -2 * 3, op held during RUN must be ignored.
        cyc(4'd2, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
        #1 chk("mult_start", 32'(start), 32'd1);
        for (int i = 0; i < MULN; i++) begin
            cyc(4'd2, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0);
            #1 chk("mult_busy", 32'(busy), 32'd1);
            chk("mult_nostart", 32'(start), 32'd0);
        end
        idle(1);
        #1 chk("mult_done", 32'(busy), 32'd0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // DIV -7 / 2.
        cyc(4'd4, 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int i = 0; i < DIVN; i++) begin
            idle(1);
            #1 chk("div_busy", 32'(busy), 32'd1);
        end
        idle(1);
        #1 chk("div_done", 32'(busy), 32'd0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // DIVU by zero keeps HI/LO but still occupies the full window.
        cyc(4'd3, 2'b00, 32'd100, 32'd0, 1'b0);
        for (int i = 0; i < DIVN; i++) begin
            idle(1);
            #1 chk("divz_busy", 32'(busy), 32'd1);
        end
        idle(1);
        #1 chk("divz_done", 32'(busy), 32'd0);
        chk("divz_lo", lo, 32'hFFFF_FFFD);
        chk("divz_hi", hi, 32'hFFFF_FFFF);

        cyc(4'd4, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        idle(DIVN + 1);
        #1 chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'd0);

        // Accumulate: HI=1, LO=all ones, +1 then signed -1.
        cyc(4'd0, 2'b11, 32'd1, 32'd0, 1'b0);
        cyc(4'd0, 2'b01, 32'hFFFF_FFFF, 32'd0, 1'b0);
        cyc(4'd5, 2'b00, 32'd1, 32'd1, 1'b0);
        idle(MULN + 1);
        #1 chk("maddu_hi", hi, 32'd2);
        chk("maddu_lo", lo, 32'd0);
        cyc(4'd8, 2'b00, 32'd1, 32'd1, 1'b0);
        idle(MULN + 1);
        #1 chk("msub_hi", hi, 32'd1);
        chk("msub_lo", lo, 32'hFFFF_FFFF);

        // Flushed op, move-to while busy, op+move-to together, flushed move-to.
        cyc(4'd1, 2'b00, 32'd7, 32'd9, 1'b1);
        #1 chk("flush_start", 32'(start), 32'd0);
        idle(1);
        #1 chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_lo", lo, 32'hFFFF_FFFF);
        cyc(4'd1, 2'b00, 32'd2, 32'd3, 1'b0);
        cyc(4'd0, 2'b01, 32'hDEAD_BEEF, 32'd0, 1'b0);
        idle(MULN);
        #1 chk("mtlo_busy_lo", lo, 32'd6);
        cyc(4'd1, 2'b01, 32'd4, 32'd5, 1'b0);
        idle(MULN + 1);
        #1 chk("op_over_mt_lo", lo, 32'd20);
        cyc(4'd0, 2'b01, 32'd55, 32'd0, 1'b1);
        idle(1);
        #1 chk("flush_mt_lo", lo, 32'd20);

        // Reset in the middle of a divide: no late commit.
        cyc(4'd4, 2'b00, 32'd100, 32'd7, 1'b0);
        idle(3);
        #3 reset_n = 1'b0;
        #1 chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_hi", hi, 32'd0);
        idle(1);
        reset_n = 1'b1;
        idle(DIVN + 2);
        #1 chk("rst_nocommit_lo", lo, 32'd0);
        chk("rst_nocommit_busy", 32'(busy), 32'd0);

        // Random traffic against the model.
        repeat (3000) begin
            logic [3:0] op;
            op = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
            cyc(op, 2'($urandom), pick(), pick(), ($urandom_range(0, 7) == 0));
            mfhilo = 2'($urandom);
        end
        idle(DIVN + 2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mdu_core.md
MDU_CORE -- requirements
Module: mdu_core

Interface
REQ-001 SHALL have parameter MUL_CYCLES, default 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port mdu_op  input  4  operation code: 0 none, 1 MULTU, 2 MULT, 3 DIVU, 4 DIV, 5 MADDU, 6 MADD, 7 MSUBU, 8 MSUB; 9-15 treated as none.
REQ-006 SHALL have port mthilo  input  2  move-to: 00 none, 01 LO<=rs_val, 11 HI<=rs_val, 10 none.
REQ-007 SHALL have port mfhilo  input  2  move-from select: 01 LO, 10 HI, other 0.
REQ-008 SHALL have port rs_val  input  32  operand A / move-to data.
REQ-009 SHALL have port rt_val  input  32  operand B.
REQ-010 SHALL have port flush  input  1  current E-stage instruction cancelled by an exception; its mdu_op/mthilo ignored.
REQ-011 SHALL have port start  output  1  combinational; 1 when a valid mdu_op is accepted this cycle.
REQ-012 SHALL have port busy  output  1  registered; 1 while an operation is in flight.
REQ-013 SHALL have port rdata  output  32  combinational HI or LO per mfhilo, else 0.
REQ-014 SHALL have ports hi, lo  output  32 each  current architectural HI/LO registers.

Function
REQ-015 SHALL use states IDLE and RUN; IDLE->RUN on accept; RUN->IDLE when down-counter reaches 1.
REQ-016 SHALL accept mdu_op only when state IDLE, flush=0 and mdu_op in 1..8; start = that condition.
REQ-017 On accept SHALL latch operands and op, load counter with MUL_CYCLES or DIV_CYCLES, set busy=1 the next edge.
REQ-018 SHALL commit HI/LO on the edge leaving RUN; busy=0 from that edge; total latency from accept edge to committed HI/LO = N cycles.
REQ-019 MULT/MULTU SHALL give {HI,LO} = 64-bit signed/unsigned product of latched A*B.
REQ-020 DIV/DIVU SHALL give LO=quotient, HI=remainder, signed truncates toward zero, remainder sign = dividend sign.
REQ-021 DIV/DIVU with B=0 SHALL leave HI and LO unchanged but still run the full DIV_CYCLES busy window.
REQ-022 DIV of 0x80000000 by 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-023 MADD/MADDU SHALL give {HI,LO} += product; MSUB/MSUBU SHALL give {HI,LO} -= product; modulo 2^64, accumulator value taken at commit.
REQ-024 mthilo SHALL write on the next edge only when IDLE and flush=0; ignored while busy.
REQ-025 mdu_op and mthilo asserted together SHALL accept only mdu_op.
REQ-026 mdu_op asserted during RUN SHALL be ignored (upstream stalls on start|busy); no queueing.
REQ-027 rdata SHALL reflect current HI/LO, including during RUN (stale values; hazard logic stalls reads).
REQ-028 flush during RUN SHALL NOT abort the in-flight operation.
REQ-029 Parameters with value 1 SHALL give busy for exactly one cycle.

Reset
REQ-030 reset_n=0 SHALL immediately clear hi, lo, counter, latched operands, state=IDLE, busy=0, regardless of clk.
REQ-031 Reset mid-RUN SHALL discard the operation; no later commit.
REQ-032 While reset_n=0, start SHALL be 0.

Verification
REQ-033 MULT A=0xFFFFFFFE (-2), B=3 -> start=1 one cycle, busy=1 for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-034 DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU with B=0 -> HI/LO unchanged.
REQ-035 mthilo=11 rs=1, then mthilo=01 rs=0xFFFFFFFF, then MADDU A=1 B=1 -> HI=2, LO=0; then MSUB A=1 B=1 -> HI=1, LO=0xFFFFFFFF.
REQ-036 MULTU issued with flush=1 -> start=0, busy stays 0, HI/LO unchanged; mthilo=01 during busy -> LO unchanged.
REQ-037 Start DIV, pulse reset_n low at busy cycle 4 -> busy=0, HI=LO=0 immediately; no commit after 10 cycles.
REQ-038 mfhilo=10 with HI=0x12345678 -> rdata=0x12345678; mfhilo=00 -> rdata=0.
